// File: rtl/byte_bus_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : byte_bus_pkg                                                    |
// | Shared frame constants and state encoding for the byte-serial memory bus. |
// | Revision: 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
package byte_bus_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    CTL   = 3'd2,
    WDATA = 3'd3,
    RDATA = 3'd4
  } bus_state_e;

  localparam int FRAME_BEATS   = 9;
  localparam int CTL_WRITE_BIT = 0;
  localparam int B_CTL         = 4;
  localparam int B_DATA0       = 5;

  function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage
`default_nettype wire

// File: rtl/byte_bus_mem_responder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : byte_bus_mem_responder_if                                     |
// | Byte-serial bus pins between the CPU-side initiator and a memory target.  |
// | Revision  : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface byte_bus_mem_responder_if;
  logic       frame;
  logic [7:0] addr_in;
  logic [7:0] bus_din;
  logic [7:0] bus_dout;
  logic       bus_oe;
  logic       busy;
  logic       err;

  modport master (
    output frame, addr_in, bus_din,
    input  bus_dout, bus_oe, busy, err
  );

  modport slave (
    input  frame, addr_in, bus_din,
    output bus_dout, bus_oe, busy, err
  );
endinterface
`default_nettype wire

// File: rtl/byte_bus_memarray.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : byte_bus_memarray                                               |
// | DEPTH x 32 register array: async clear, comb read, full-word sync write.  |
// | Revision: 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module byte_bus_memarray #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic          we,
  input  wire logic [AW-1:0] waddr,
  input  wire logic [31:0]   wdata,
  input  wire logic [AW-1:0] raddr,
  output logic [31:0]        rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 32'd0;
      end
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/byte_bus_mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : byte_bus_mem_responder                                          |
// | Byte-serial bus target serving 9-beat frames from a local word memory.    |
// | Option  : MEMRESP_TXN_CNT_EN adds txn_count (completed-frame counter).    |
// | Revision: 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module byte_bus_mem_responder
  import byte_bus_pkg::*;
#(
  parameter int          DEPTH = 16,
  parameter logic [31:0] BASE  = 32'h0000_0000
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  byte_bus_mem_responder_if.slave bus
`ifdef MEMRESP_TXN_CNT_EN
  ,
  output logic [15:0]             txn_count
`endif
);

  localparam int AW = $clog2(DEPTH);

  bus_state_e  r_state, w_state_nxt;
  logic [1:0]  r_cnt, w_cnt_nxt;
  logic [3:0]  w_beat;
  logic [31:0] r_addr;
  logic [23:0] r_wbuf;
  logic [31:0] r_rword;
  logic [7:0]  r_dout;
  logic        r_oe;
  logic        r_err;

  logic          w_hit;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_rdata;
  logic [31:0]   w_rsnap;
  logic          w_last;
  logic          w_we;

  assign w_hit   = (r_addr[31:AW+2] == BASE[31:AW+2]) && (r_addr[1:0] == 2'b00);
  assign w_idx   = r_addr[AW+1:2];
  assign w_rsnap = w_hit ? w_rdata : 32'd0;

  // Absolute beat number of the current cycle; only meaningful outside IDLE.
  always_comb begin
    w_beat = 4'd0;
    case (r_state)
      ADDR:         w_beat = {2'b00, r_cnt};
      CTL:          w_beat = 4'(B_CTL);
      WDATA, RDATA: w_beat = 4'(B_DATA0) + {2'b00, r_cnt};
      default:      w_beat = 4'd0;
    endcase
  end

  assign w_last = ((r_state == WDATA) || (r_state == RDATA)) &&
                  (w_beat == 4'(FRAME_BEATS - 1)) && !bus.frame;
  assign w_we   = (r_state == WDATA) && w_last && w_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // frame wins in every state: it always opens a fresh frame at address byte 0.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (bus.frame) begin
      w_state_nxt = ADDR;
      w_cnt_nxt   = 2'd1;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 2'd0;
        end
        ADDR: begin
          if (r_cnt == 2'd3) begin
            w_state_nxt = CTL;
            w_cnt_nxt   = 2'd0;
          end else begin
            w_cnt_nxt = r_cnt + 2'd1;
          end
        end
        CTL: begin
          w_state_nxt = bus.addr_in[CTL_WRITE_BIT] ? WDATA : RDATA;
          w_cnt_nxt   = 2'd0;
        end
        WDATA, RDATA: begin
          if (r_cnt == 2'd3) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 2'd0;
          end else begin
            w_cnt_nxt = r_cnt + 2'd1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= 32'd0;
      r_wbuf  <= 24'd0;
      r_rword <= 32'd0;
      r_dout  <= 8'd0;
      r_oe    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_last && !w_hit;
      if (bus.frame) begin
        r_addr[7:0] <= bus.addr_in;
        r_oe        <= 1'b0;
        r_dout      <= 8'd0;
      end else begin
        case (r_state)
          ADDR: r_addr[{r_cnt, 3'b000} +: 8] <= bus.addr_in;
          CTL: begin
            // Snapshot the whole word so later writes cannot tear a read.
            if (!bus.addr_in[CTL_WRITE_BIT]) begin
              r_oe    <= 1'b1;
              r_rword <= w_rsnap;
              r_dout  <= w_rsnap[7:0];
            end
          end
          WDATA: begin
            case (r_cnt)
              2'd0:    r_wbuf[7:0]   <= bus.bus_din;
              2'd1:    r_wbuf[15:8]  <= bus.bus_din;
              2'd2:    r_wbuf[23:16] <= bus.bus_din;
              default: ;
            endcase
          end
          RDATA: begin
            if (r_cnt == 2'd3) begin
              r_oe   <= 1'b0;
              r_dout <= 8'd0;
            end else begin
              r_dout <= byte_of(r_rword, r_cnt + 2'd1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  byte_bus_memarray #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_memarray (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (w_we),
    .waddr (w_idx),
    .wdata ({bus.bus_din, r_wbuf}),
    .raddr (w_idx),
    .rdata (w_rdata)
  );

`ifdef MEMRESP_TXN_CNT_EN
  logic [15:0] r_txn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_txn <= 16'd0;
    end else if (w_last) begin
      r_txn <= r_txn + 16'd1;
    end
  end

  assign txn_count = r_txn;
`endif

  assign bus.bus_dout = r_dout;
  assign bus.bus_oe   = r_oe;
  assign bus.err      = r_err;
  assign bus.busy     = bus.frame || (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_byte_bus_mem_responder.sv
`default_nettype none
// Directed bench for byte_bus_mem_responder (DEPTH=16, BASE=0); expected
// values are hand-derived from the frame protocol.
module tb_byte_bus_mem_responder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  byte_bus_mem_responder_if bif ();

`ifdef MEMRESP_TXN_CNT_EN
  logic [15:0] txn_count;
`endif

  byte_bus_mem_responder #(
    .DEPTH (16),
    .BASE  (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bif.slave)
`ifdef MEMRESP_TXN_CNT_EN
    ,
    .txn_count (txn_count)
`endif
  );

  int   tests    = 0;
  int   fails    = 0;
  int   exp_txn  = 0;
  logic trk      = 1'b0;
  logic busy_gap = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one beat, let it be sampled, then settle 1 time unit past the edge.
  task automatic step(input logic f, input logic [7:0] a, input logic [7:0] d);
    bif.frame   = f;
    bif.addr_in = a;
    bif.bus_din = d;
    #1;
    if (trk && bif.busy !== 1'b1) busy_gap = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic hdr(input logic [31:0] addr, input logic [7:0] ctl);
    step(1'b1, addr[7:0], 8'h00);
    step(1'b0, addr[15:8], 8'h00);
    step(1'b0, addr[23:16], 8'h00);
    step(1'b0, addr[31:24], 8'h00);
    step(1'b0, ctl, 8'h00);
  endtask

  task automatic data_phase(input string tag, input logic [7:0] ctl, input logic [31:0] wd,
                            input logic [31:0] exp_rd, input logic exp_err);
    logic [7:0] b;
    if (!ctl[0]) begin
      chk({tag, ".oe_b4"}, 32'(bif.bus_oe), 32'd1);
      chk({tag, ".byte0"}, 32'(bif.bus_dout), 32'(exp_rd[7:0]));
    end else begin
      chk({tag, ".oe_wr"}, 32'(bif.bus_oe), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      b = wd[8*i +: 8];
      step(1'b0, 8'h00, b);
      if (!ctl[0] && i < 3)
        chk($sformatf("%s.byte%0d", tag, i + 1), 32'(bif.bus_dout), 32'(exp_rd[8*(i+1) +: 8]));
    end
    chk({tag, ".oe_end"}, 32'(bif.bus_oe), 32'd0);
    chk({tag, ".dout_end"}, 32'(bif.bus_dout), 32'd0);
    chk({tag, ".err"}, 32'(bif.err), 32'(exp_err));
    exp_txn++;
`ifdef MEMRESP_TXN_CNT_EN
    chk({tag, ".txn"}, 32'(txn_count), 32'(exp_txn & 16'hFFFF));
`endif
  endtask

  task automatic frame(input string tag, input logic [31:0] addr, input logic [7:0] ctl,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
    hdr(addr, ctl);
    data_phase(tag, ctl, wd, exp_rd, exp_err);
  endtask

  task automatic idle_err(input string tag);
    step(1'b0, 8'h00, 8'h00);
    chk({tag, ".err_clear"}, 32'(bif.err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    bif.frame   = 1'b0;
    bif.addr_in = 8'h00;
    bif.bus_din = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.oe", 32'(bif.bus_oe), 32'd0);
    chk("rst.dout", 32'(bif.bus_dout), 32'd0);
    chk("rst.err", 32'(bif.err), 32'd0);
    chk("rst.busy", 32'(bif.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    frame("wr8", 32'h0000_0008, 8'h01, 32'h1234_5678, 32'h0, 1'b0);
    idle_err("wr8");
    frame("rd8", 32'h0000_0008, 8'h00, 32'h0, 32'h1234_5678, 1'b0);
    idle_err("rd8");

    // Out-of-range: 0x40 would alias to word 0 if decode ignored upper bits.
    frame("wr40", 32'h0000_0040, 8'h01, 32'hDEAD_BEEF, 32'h0, 1'b1);
    idle_err("wr40");
    frame("rd40", 32'h0000_0040, 8'h00, 32'h0, 32'h0, 1'b1);
    idle_err("rd40");
    frame("rd0", 32'h0000_0000, 8'hFE, 32'h0, 32'h0, 1'b0);
    idle_err("rd0");

    frame("rd5", 32'h0000_0005, 8'h00, 32'h0, 32'h0, 1'b1);
    idle_err("rd5");
    frame("wr9", 32'h0000_0009, 8'h01, 32'hAAAA_AAAA, 32'h0, 1'b1);
    idle_err("wr9");
    frame("wrhi", 32'h8000_0008, 8'hFF, 32'h5555_5555, 32'h0, 1'b1);
    idle_err("wrhi");
    frame("rd8b", 32'h0000_0008, 8'h00, 32'h0, 32'h1234_5678, 1'b0);
    idle_err("rd8b");

    frame("wr3c", 32'h0000_003C, 8'h01, 32'h89AB_CDEF, 32'h0, 1'b0);
    idle_err("wr3c");
    frame("rd3c", 32'h0000_003C, 8'h00, 32'h0, 32'h89AB_CDEF, 1'b0);
    idle_err("rd3c");

    // Abort a write to word 2 at B6 with a read of the same word.
    hdr(32'h0000_0008, 8'h01);
    step(1'b0, 8'h00, 8'h0D);
    frame("abrt_wr", 32'h0000_0008, 8'h00, 32'h0, 32'h1234_5678, 1'b0);
    idle_err("abrt_wr");

    // Abort a missing read at B7; its err must never appear.
    hdr(32'h0000_0044, 8'h00);
    step(1'b0, 8'h00, 8'h00);
    step(1'b0, 8'h00, 8'h00);
    chk("abrt_rd.oe_before", 32'(bif.bus_oe), 32'd1);
    step(1'b1, 8'h08, 8'h00);
    chk("abrt_rd.oe_drop", 32'(bif.bus_oe), 32'd0);
    step(1'b0, 8'h00, 8'h00);
    chk("abrt_rd.no_err", 32'(bif.err), 32'd0);
    step(1'b0, 8'h00, 8'h00);
    step(1'b0, 8'h00, 8'h00);
    step(1'b0, 8'h00, 8'h00);
    data_phase("abrt_rd", 8'h00, 32'h0, 32'h1234_5678, 1'b0);
    idle_err("abrt_rd");

    // Back-to-back frames with no idle gap.
    trk      = 1'b1;
    busy_gap = 1'b0;
    frame("bb_wr", 32'h0000_0004, 8'h01, 32'h1122_3344, 32'h0, 1'b0);
    frame("bb_rd", 32'h0000_0004, 8'h00, 32'h0, 32'h1122_3344, 1'b0);
    trk = 1'b0;
    chk("bb.busy_gap", 32'(busy_gap), 32'd0);
    idle_err("bb");

    // Asynchronous reset in the middle of a read data phase.
    hdr(32'h0000_0008, 8'h00);
    step(1'b0, 8'h00, 8'h00);
    chk("rstmid.dout_b5", 32'(bif.bus_dout), 32'h56);
    bif.frame   = 1'b0;
    bif.bus_din = 8'h00;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid.oe", 32'(bif.bus_oe), 32'd0);
    chk("rstmid.dout", 32'(bif.bus_dout), 32'd0);
    chk("rstmid.busy", 32'(bif.busy), 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    exp_txn = 0;
    @(posedge clk);
    #1;
    frame("post_rd8", 32'h0000_0008, 8'h00, 32'h0, 32'h0, 1'b0);
    idle_err("post_rd8");
    frame("post_rd3c", 32'h0000_003C, 8'h00, 32'h0, 32'h0, 1'b0);
    idle_err("post_rd3c");
    frame("post_rd4", 32'h0000_0004, 8'h00, 32'h0, 32'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
